// File: rtl/spi_master_if.sv
// CPU slave-bus port of the SPI master peripheral.
//
// Handshake: the decoder raises spi_valid for exactly one cycle per access,
// with spi_addr/spi_wdata/spi_wstrb/spi_instr stable in that cycle. The
// peripheral answers with spi_ready high for exactly one cycle, the cycle
// after valid. spi_rdata is meaningful only while spi_ready is high and is
// 0 otherwise. spi_wstrb != 0 marks a write, spi_wstrb == 0 a read. A new
// valid may be issued every cycle and each one receives its own ready.
//
// Signals: spi_valid, spi_instr, spi_addr[31:0], spi_wdata[31:0],
//          spi_wstrb[3:0] (master -> slave); spi_rdata[31:0], spi_ready
//          (slave -> master).
interface spi_master_if;
  logic        spi_valid;
  logic        spi_instr;
  logic [31:0] spi_addr;
  logic [31:0] spi_wdata;
  logic [3:0]  spi_wstrb;
  logic [31:0] spi_rdata;
  logic        spi_ready;

  modport master (
    output spi_valid, spi_instr, spi_addr, spi_wdata, spi_wstrb,
    input  spi_rdata, spi_ready
  );

  modport slave (
    input  spi_valid, spi_instr, spi_addr, spi_wdata, spi_wstrb,
    output spi_rdata, spi_ready
  );
endinterface

// File: rtl/spi_master.sv
// Memory-mapped SPI master (mode 0, MSB first) with TX/RX byte FIFOs and a
// programmable half-period divider.
//
// spi_fifo  : byte FIFO, power-of-two depth, wrap-around pointers + count.
// spi_master: clk, rst (sync, active low), bus (spi_master_if.slave),
//             spi_sck/spi_mosi/spi_cs_n out, spi_miso in,
//             dbg_state (current engine state encoding).
// Registers by addr[3:2]: 0 DATA, 1 STATUS, 2 CTRL {cs_en, div}, 3 reserved.
module spi_fifo #(
  parameter int depth = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

  logic [7:0]    mem [depth];
  logic [aw-1:0] wptr;
  logic [aw-1:0] rptr;
  logic [aw:0]   cnt;

  assign dout  = mem[rptr];
  assign full  = (cnt == full_cnt);
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Callers only pop when non-empty and only push when there is room
  // (or a same-cycle pop frees a slot).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module spi_master #(
  parameter int          fifo_depth = 4,
  parameter logic [15:0] div_reset  = 16'd49
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_if.slave      bus,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {
    st_idle, st_load, st_low, st_high, st_done
  } state_t;

  state_t      state, state_n;
  logic [7:0]  shreg;
  logic [2:0]  bitcnt;
  logic [15:0] div_cnt;
  logic [15:0] cur_div;     // divisor latched at each half-period boundary
  logic [15:0] ctrl_div;
  logic        cs_en;
  logic        tx_ovf, rx_ovf;

  logic [7:0]  tx_dout, rx_dout;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        eng_push, half_done, busy;
  logic [31:0] rd_val;

  // Bus decode; only addr[3:2] selects a register.
  logic [1:0] reg_sel;
  logic       is_write, data_wr, data_rd, stat_wr, ctrl_wr;
  assign reg_sel  = bus.spi_addr[3:2];
  assign is_write = (bus.spi_wstrb != 4'b0);
  assign data_wr  = bus.spi_valid &&  is_write && (reg_sel == 2'd0);
  assign data_rd  = bus.spi_valid && !is_write && (reg_sel == 2'd0);
  assign stat_wr  = bus.spi_valid &&  is_write && (reg_sel == 2'd1);
  assign ctrl_wr  = bus.spi_valid &&  is_write && (reg_sel == 2'd2);

  // A push into a full FIFO is fine when the other side pops that cycle.
  assign tx_push = data_wr && (!tx_full || tx_pop);
  assign rx_pop  = data_rd && !rx_empty;
  assign rx_push = eng_push && (!rx_full || rx_pop);

  spi_fifo #(.depth(fifo_depth)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .din(bus.spi_wdata[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  spi_fifo #(.depth(fifo_depth)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .din(shreg), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign busy      = (state != st_idle) || !tx_empty;
  assign half_done = (div_cnt == cur_div);
  assign spi_cs_n  = ~cs_en;
  assign dbg_state = state;

  // Engine next-state and strobes.
  always_comb begin
    state_n  = state;
    tx_pop   = 1'b0;
    eng_push = 1'b0;
    unique case (state)
      st_idle: if (!tx_empty) state_n = st_load;
      st_load: begin
        tx_pop  = 1'b1;
        state_n = st_low;
      end
      st_low:  if (half_done) state_n = st_high;
      st_high: if (half_done) state_n = (bitcnt == 3'd0) ? st_done : st_low;
      st_done: begin
        eng_push = 1'b1;
        state_n  = st_idle;
      end
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= st_idle;
      shreg    <= '0;
      bitcnt   <= '0;
      div_cnt  <= '0;
      cur_div  <= '0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        st_load: begin
          shreg    <= tx_dout;
          bitcnt   <= 3'd7;
          spi_mosi <= tx_dout[7];
          div_cnt  <= '0;
          cur_div  <= ctrl_div;
        end
        st_low: begin
          if (half_done) begin
            // Rising edge: shifting miso in at the LSB also moves the next
            // outgoing bit into shreg[7].
            spi_sck <= 1'b1;
            shreg   <= {shreg[6:0], spi_miso};
            div_cnt <= '0;
            cur_div <= ctrl_div;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        st_high: begin
          if (half_done) begin
            spi_sck <= 1'b0;
            div_cnt <= '0;
            cur_div <= ctrl_div;
            if (bitcnt != 3'd0) begin
              bitcnt   <= bitcnt - 1'b1;
              spi_mosi <= shreg[7];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux for the current request.
  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      2'd0: rd_val = rx_empty ? 32'd0 : {24'b0, rx_dout};
      2'd1: rd_val = {25'b0, rx_ovf, tx_ovf, rx_empty, rx_full,
                      tx_empty, tx_full, busy};
      2'd2: rd_val = {15'b0, cs_en, ctrl_div};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.spi_ready <= 1'b0;
      bus.spi_rdata <= '0;
      ctrl_div      <= div_reset;
      cs_en         <= 1'b0;
      tx_ovf        <= 1'b0;
      rx_ovf        <= 1'b0;
    end else begin
      bus.spi_ready <= bus.spi_valid;
      bus.spi_rdata <= (bus.spi_valid && !is_write) ? rd_val : 32'd0;

      if (data_wr && tx_full && !tx_pop)      tx_ovf <= 1'b1;
      else if (stat_wr && bus.spi_wdata[5])   tx_ovf <= 1'b0;

      if (eng_push && rx_full && !rx_pop)     rx_ovf <= 1'b1;
      else if (stat_wr && bus.spi_wdata[6])   rx_ovf <= 1'b0;

      if (ctrl_wr) begin
        if (bus.spi_wstrb[0]) ctrl_div[7:0]  <= bus.spi_wdata[7:0];
        if (bus.spi_wstrb[1]) ctrl_div[15:8] <= bus.spi_wdata[15:8];
        if (bus.spi_wstrb[2]) cs_en          <= bus.spi_wdata[16];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.spi_instr, bus.spi_addr[31:4], bus.spi_addr[1:0],
                         bus.spi_wdata[31:17], bus.spi_wstrb[3]};
endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        loop_en = 1'b1;
  logic        miso_force = 1'b0;
  logic        spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic [2:0]  dbg_state;

  spi_master_if bus();

  assign spi_miso = loop_en ? spi_mosi : miso_force;

  spi_master #(.fifo_depth(4), .div_reset(16'd49)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];   // bytes that must appear on mosi, in order
  logic [7:0] rx_q[$];    // bytes the RX FIFO must return, in order

  // Behavioural model of bus-visible control state, updated at each edge.
  logic        e_rst = 1'b1;
  logic        e_ready = 1'b0;
  logic [15:0] m_div = 16'd49;
  logic        m_cs_en = 1'b0;

  // Serial monitor state.
  int          rises = 0;
  int          bitn = 0;
  int          hi_len = 0;
  int          lo_len = 0;
  int          first_rise_cyc = -1;
  logic        prev_sck = 1'b0;
  logic [7:0]  cur_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    bus.spi_valid = 1'b0;
    bus.spi_instr = 1'b0;
    bus.spi_addr  = '0;
    bus.spi_wdata = '0;
    bus.spi_wstrb = '0;
  end

  // Edge capture: what each edge must have done, from the register rules.
  initial forever begin
    @(posedge clk);
    cyc++;
    e_rst   = !rst;
    e_ready = rst && bus.spi_valid;
    if (!rst) begin
      m_div   = 16'd49;
      m_cs_en = 1'b0;
    end else if (bus.spi_valid && bus.spi_wstrb != 4'b0 && bus.spi_addr[3:2] == 2'd2) begin
      if (bus.spi_wstrb[0]) m_div[7:0]  = bus.spi_wdata[7:0];
      if (bus.spi_wstrb[1]) m_div[15:8] = bus.spi_wdata[15:8];
      if (bus.spi_wstrb[2]) m_cs_en     = bus.spi_wdata[16];
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    check("ready", 32'(bus.spi_ready), 32'(e_ready));
    if (!bus.spi_ready) check("rdata_idle", bus.spi_rdata, 32'd0);
    check("cs_n", 32'(spi_cs_n), 32'(!m_cs_en));
    if (e_rst) begin
      check("sck_after_rst", 32'(spi_sck), 32'd0);
      bitn = 0; hi_len = 0; lo_len = 0; prev_sck = 1'b0;
    end else begin
      if (spi_sck && !prev_sck) begin
        rises++;
        if (bitn == 0) first_rise_cyc = cyc;
        else check("sck_low_width", 32'(lo_len), 32'(m_div) + 32'd1);
        cur_byte = {cur_byte[6:0], spi_mosi};
        bitn++;
        if (bitn == 8) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL mosi_byte: got %h with no byte expected", cur_byte);
          end else begin
            check("mosi_byte", 32'(cur_byte), 32'(exp_q.pop_front()));
          end
          bitn = 0;
        end
      end
      if (!spi_sck && prev_sck) check("sck_high_width", 32'(hi_len), 32'(m_div) + 32'd1);
      if (spi_sck) begin hi_len++; lo_len = 0; end
      else begin hi_len = 0; lo_len++; end
      prev_sck = spi_sck;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_op(input logic [1:0] reg_idx, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd);
    logic [31:0] a;
    a = $urandom();
    a[3:2] = reg_idx;
    @(negedge clk);
    bus.spi_valid = 1'b1;
    bus.spi_addr  = a;
    bus.spi_wdata = wd;
    bus.spi_wstrb = ws;
    bus.spi_instr = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.spi_valid = 1'b0;
    bus.spi_wstrb = 4'b0;
    rd = bus.spi_rdata;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] x;
    bus_op(r, d, 4'hF, x);
  endtask

  task automatic rd_check(input logic [1:0] r, input logic [31:0] exp, input string name);
    logic [31:0] x;
    bus_op(r, 32'd0, 4'b0, x);
    check(name, x, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr(2'd0, {24'b0, b});
    exp_q.push_back(b);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int i;
    st = 32'd1;
    for (i = 0; i < 400 && st[0]; i++) bus_op(2'd1, 32'd0, 4'b0, st);
    check("wait_idle_budget", 32'(st[0]), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.spi_valid = 1'b0;
    bus.spi_wstrb = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rx_status(input int n);
    return 32'h04 | ((n == 4) ? 32'h08 : 32'h0) | ((n == 0) ? 32'h10 : 32'h0);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] st;
    logic [7:0]  b;
    int          r0, t_clear, k;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_sck", 32'(spi_sck), 32'd0);
    check("reset_cs_n", 32'(spi_cs_n), 32'd1);
    check("reset_ready", 32'(bus.spi_ready), 32'd0);
    rd_check(2'd1, 32'h14, "reset_status");
    rd_check(2'd2, 32'h31, "reset_ctrl");
    rd_check(2'd3, 32'h0, "reserved_read");

    // Single byte, div=0, loopback
    wr(2'd2, 32'h0001_0000);
    check("cs_n_enabled", 32'(spi_cs_n), 32'd0);
    r0 = rises;
    send_byte(8'hA5);
    rx_q.push_back(8'hA5);
    @(negedge clk);
    bus.spi_valid = 1'b1; bus.spi_addr = 32'h4; bus.spi_wstrb = 4'b0;
    t_clear = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      st = bus.spi_rdata;
      if (!st[0] && t_clear < 0) t_clear = cyc - 1;
    end
    bus.spi_valid = 1'b0;
    check("busy_clear_after_first_rise", 32'(t_clear - first_rise_cyc), 32'd16);
    check("single_rises", 32'(rises - r0), 32'd8);
    rd_check(2'd0, 32'h0000_00A5, "single_rx");
    void'(rx_q.pop_front());
    rd_check(2'd0, 32'h0, "empty_rx_read");

    // Randomized rounds with loopback
    for (int r = 0; r < 8; r++) begin
      logic [31:0] cd;
      cd = $urandom();
      bus_op(2'd2, cd, 4'($urandom_range(1, 15)), st);
      rd_check(2'd2, {15'b0, m_cs_en, m_div}, "ctrl_lanes");
      wr(2'd2, {15'b0, 1'b1, 16'($urandom_range(0, 3))});
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom());
        send_byte(b);
        rx_q.push_back(b);
      end
      wait_idle();
      rd_check(2'd1, rx_status(rx_q.size()), "rand_status");
      while (rx_q.size() > 0) rd_check(2'd0, {24'b0, rx_q.pop_front()}, "rand_rx");
      check("rand_exp_drained", 32'(exp_q.size()), 32'd0);
    end

    // TX overflow with a very slow clock
    wr(2'd2, 32'h0001_FFFF);
    for (int j = 0; j < 6; j++) wr(2'd0, 32'($urandom_range(0, 255)));
    rd_check(2'd1, 32'h33, "tx_ovf_status");
    wr(2'd1, 32'h20);
    rd_check(2'd1, 32'h13, "tx_ovf_cleared");
    do_reset();
    rd_check(2'd1, 32'h14, "after_ovf_reset_status");

    // RX full, miso held high
    wr(2'd2, 32'h0001_0000);
    loop_en = 1'b0; miso_force = 1'b1;
    for (int j = 0; j < 6; j++) begin
      send_byte(8'($urandom()));
      wait_idle();
    end
    rd_check(2'd1, 32'h4C, "rx_full_status");
    for (int j = 0; j < 4; j++) rd_check(2'd0, 32'hFF, "rx_full_data");
    rd_check(2'd0, 32'h0, "rx_drained_read");
    rd_check(2'd1, 32'h54, "rx_drained_status");
    wr(2'd1, 32'h40);
    rd_check(2'd1, 32'h14, "rx_ovf_cleared");

    // Same-cycle pop and DONE push into a full RX
    loop_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      b = 8'($urandom());
      send_byte(b);
      rx_q.push_back(b);
      wait_idle();
    end
    @(negedge clk);
    bus.spi_valid = 1'b1; bus.spi_addr = 32'h0; bus.spi_wdata = 32'h5A; bus.spi_wstrb = 4'hF;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    bus.spi_valid = 1'b0; bus.spi_wstrb = 4'b0;
    repeat (18) @(negedge clk);
    bus.spi_valid = 1'b1; bus.spi_addr = 32'h0;
    @(negedge clk);
    bus.spi_valid = 1'b0;
    check("concurrent_pop", bus.spi_rdata, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'h5A);
    rd_check(2'd1, 32'h0C, "concurrent_status");
    while (rx_q.size() > 0) rd_check(2'd0, {24'b0, rx_q.pop_front()}, "concurrent_rx");

    // Reset in the middle of a byte
    wr(2'd2, 32'h0001_0001);
    r0 = rises;
    wr(2'd0, 32'hC3);
    for (int i = 0; i < 200 && (rises - r0) < 3; i++) @(negedge clk);
    check("mid_rises", 32'(rises - r0), 32'd3);
    rst = 1'b0;
    bus.spi_valid = 1'b1; bus.spi_addr = 32'h4; bus.spi_wstrb = 4'b0;
    @(negedge clk);
    bus.spi_valid = 1'b0;
    check("mid_rst_sck", 32'(spi_sck), 32'd0);
    check("mid_rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("mid_rst_ready", 32'(bus.spi_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rd_check(2'd1, 32'h14, "mid_rst_status");
    rd_check(2'd2, 32'h31, "mid_rst_ctrl");
    repeat (10) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
